// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
// Holds the register index width, the default data width and the grant encoding.
package regfile_wb_arbiter_pkg;

    localparam int REG_IDX_W    = 5;
    localparam int XLEN_DEFAULT = 32;

    localparam logic [REG_IDX_W-1:0] ZERO_REG = 5'd0;

    typedef enum logic {
        GNT_A = 1'b0,
        GNT_B = 1'b1
    } grant_e;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback requesters, issue tracking, decode busy lookup and register-file write port.
// Macro WB_BYPASS_EN adds the rs1_fwd/rs2_fwd forwarding signals.
interface regfile_wb_arbiter_if
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
);

    // Handshake: a transfer happens on a rising edge where valid && ready are both high;
    // ready is combinational and may depend on valid; requesters hold rd/data until ready.
    logic                 a_valid;
    logic                 a_ready;
    logic [REG_IDX_W-1:0] a_rd;
    logic [XLEN-1:0]      a_data;

    logic                 b_valid;
    logic                 b_ready;
    logic [REG_IDX_W-1:0] b_rd;
    logic [XLEN-1:0]      b_data;

    logic                 issue_valid;
    logic [REG_IDX_W-1:0] issue_rd;

    logic [REG_IDX_W-1:0] rs1;
    logic [REG_IDX_W-1:0] rs2;
    logic                 rs1_busy;
    logic                 rs2_busy;

    logic                 reg_write;
    logic [REG_IDX_W-1:0] wr_rd;
    logic [XLEN-1:0]      wr_data;

`ifdef WB_BYPASS_EN
    logic [XLEN-1:0]      rs1_fwd;
    logic [XLEN-1:0]      rs2_fwd;
`endif

    modport slave (
        input  a_valid, a_rd, a_data,
        input  b_valid, b_rd, b_data,
        input  issue_valid, issue_rd,
        input  rs1, rs2,
        output a_ready, b_ready,
        output rs1_busy, rs2_busy,
        output reg_write, wr_rd, wr_data
`ifdef WB_BYPASS_EN
        , output rs1_fwd, rs2_fwd
`endif
    );

    modport master (
        output a_valid, a_rd, a_data,
        output b_valid, b_rd, b_data,
        output issue_valid, issue_rd,
        output rs1, rs2,
        input  a_ready, b_ready,
        input  rs1_busy, rs2_busy,
        input  reg_write, wr_rd, wr_data
`ifdef WB_BYPASS_EN
        , input rs1_fwd, rs2_fwd
`endif
    );

endinterface

// File: rtl/regfile_wb_arbiter_wb_scoreboard.sv
// Pending-write scoreboard: tracks in-flight long-latency destinations for RAW stalls.
// Macro WB_BYPASS_EN lets a write in flight this cycle forward its data instead of stalling.
module wb_scoreboard
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int NUM_REGS = 32
`ifdef WB_BYPASS_EN
    , parameter int XLEN   = XLEN_DEFAULT
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 set_valid,
    input  logic [REG_IDX_W-1:0] set_rd,
    input  logic                 clr_valid,
    input  logic [REG_IDX_W-1:0] clr_rd,
    input  logic [REG_IDX_W-1:0] rs1,
    input  logic [REG_IDX_W-1:0] rs2,
    output logic                 rs1_busy,
    output logic                 rs2_busy
`ifdef WB_BYPASS_EN
    , input  logic [XLEN-1:0]    wr_data
    , output logic [XLEN-1:0]    rs1_fwd
    , output logic [XLEN-1:0]    rs2_fwd
`endif
);

    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] pending_nxt;

    // Set is applied after clear so a fresh issue supersedes the retiring write.
    always_comb begin
        pending_nxt = pending;
        if (clr_valid && clr_rd != ZERO_REG) pending_nxt[clr_rd] = 1'b0;
        if (set_valid && set_rd != ZERO_REG) pending_nxt[set_rd] = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) pending <= '0;
        else        pending <= pending_nxt;
    end

`ifdef WB_BYPASS_EN
    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit  = clr_valid && clr_rd == rs1 && rs1 != ZERO_REG;
    assign rs2_hit  = clr_valid && clr_rd == rs2 && rs2 != ZERO_REG;
    assign rs1_busy = pending[rs1] && rs1 != ZERO_REG && !rs1_hit;
    assign rs2_busy = pending[rs2] && rs2 != ZERO_REG && !rs2_hit;
    assign rs1_fwd  = rs1_hit ? wr_data : '0;
    assign rs2_fwd  = rs2_hit ? wr_data : '0;
`else
    assign rs1_busy = pending[rs1] && rs1 != ZERO_REG;
    assign rs2_busy = pending[rs2] && rs2 != ZERO_REG;
`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Two-port writeback arbiter driving the single register-file write port, plus scoreboard.
// Macro WB_BYPASS_EN enables same-cycle forwarding of the registered write to decode.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int XLEN     = XLEN_DEFAULT,
    parameter int NUM_REGS = 32,
    parameter int ARB_MODE = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_wb_arbiter_if.slave  bus
);

    grant_e               last_grant;
    logic                 a_ready;
    logic                 b_ready;
    logic                 a_pref;
    logic                 reg_write_q;
    logic [REG_IDX_W-1:0] wr_rd_q;
    logic [XLEN-1:0]      wr_data_q;

    // A is preferred under contention in fixed mode, or in round-robin when B won last.
    assign a_pref  = (ARB_MODE != 0) || (last_grant == GNT_B);
    assign a_ready = rst_n && bus.a_valid && (!bus.b_valid || a_pref);
    assign b_ready = rst_n && bus.b_valid && (!bus.a_valid || !a_pref);

    assign bus.a_ready = a_ready;
    assign bus.b_ready = b_ready;

    // Writes to x0 still consume the grant but never reach the register file.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            reg_write_q <= 1'b0;
            wr_rd_q     <= ZERO_REG;
            wr_data_q   <= '0;
            last_grant  <= GNT_B;
        end else begin
            reg_write_q <= 1'b0;
            if (a_ready) begin
                last_grant <= GNT_A;
                if (bus.a_rd != ZERO_REG) begin
                    reg_write_q <= 1'b1;
                    wr_rd_q     <= bus.a_rd;
                    wr_data_q   <= bus.a_data;
                end
            end else if (b_ready) begin
                last_grant <= GNT_B;
                if (bus.b_rd != ZERO_REG) begin
                    reg_write_q <= 1'b1;
                    wr_rd_q     <= bus.b_rd;
                    wr_data_q   <= bus.b_data;
                end
            end
        end
    end

    assign bus.reg_write = reg_write_q;
    assign bus.wr_rd     = wr_rd_q;
    assign bus.wr_data   = wr_data_q;

    wb_scoreboard #(
        .NUM_REGS (NUM_REGS)
`ifdef WB_BYPASS_EN
        , .XLEN   (XLEN)
`endif
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .set_valid (bus.issue_valid),
        .set_rd    (bus.issue_rd),
        .clr_valid (reg_write_q),
        .clr_rd    (wr_rd_q),
        .rs1       (bus.rs1),
        .rs2       (bus.rs2),
        .rs1_busy  (bus.rs1_busy),
        .rs2_busy  (bus.rs2_busy)
`ifdef WB_BYPASS_EN
        , .wr_data (wr_data_q)
        , .rs1_fwd (bus.rs1_fwd)
        , .rs2_fwd (bus.rs2_fwd)
`endif
    );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: round-robin and fixed-priority instances side by side.
// Inputs change 1ns after a rising edge; outputs are compared before the next edge.
module tb_regfile_wb_arbiter;
    import regfile_wb_arbiter_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    regfile_wb_arbiter_if #(.XLEN(32)) bus0 ();
    regfile_wb_arbiter_if #(.XLEN(32)) bus1 ();

    regfile_wb_arbiter #(.XLEN(32), .NUM_REGS(32), .ARB_MODE(0)) dut_rr (
        .clk (clk), .rst_n (rst_n), .bus (bus0.slave)
    );

    regfile_wb_arbiter #(.XLEN(32), .NUM_REGS(32), .ARB_MODE(1)) dut_fp (
        .clk (clk), .rst_n (rst_n), .bus (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus0.a_valid = 0; bus0.a_rd = 0; bus0.a_data = 0;
        bus0.b_valid = 0; bus0.b_rd = 0; bus0.b_data = 0;
        bus0.issue_valid = 0; bus0.issue_rd = 0; bus0.rs1 = 0; bus0.rs2 = 0;
        bus1.a_valid = 0; bus1.a_rd = 0; bus1.a_data = 0;
        bus1.b_valid = 0; bus1.b_rd = 0; bus1.b_data = 0;
        bus1.issue_valid = 0; bus1.issue_rd = 0; bus1.rs1 = 0; bus1.rs2 = 0;
    endtask

    task automatic reset_dut();
        idle_inputs();
        rst_n = 0;
        cyc();
        rst_n = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        bus0.a_valid = 1; bus0.a_rd = 5; bus0.a_data = 32'h11; bus0.rs1 = 7;
        cyc(); cyc();
        checks++; if (bus0.a_ready !== 1'b0) begin errors++; $display("FAIL reset_a_ready: got %b expected 0", bus0.a_ready); end
        checks++; if (bus0.reg_write !== 1'b0) begin errors++; $display("FAIL reset_reg_write: got %b expected 0", bus0.reg_write); end
        checks++; if (bus0.wr_rd !== 5'd0 || bus0.wr_data !== 32'h0) begin errors++; $display("FAIL reset_wr: got rd=%0d data=%h expected 0/0", bus0.wr_rd, bus0.wr_data); end
        checks++; if (bus0.rs1_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus0.rs1_busy); end
        rst_n = 1;
        #1;
        checks++; if (bus0.a_ready !== 1'b1) begin errors++; $display("FAIL release_a_ready: got %b expected 1", bus0.a_ready); end
        cyc();
        bus0.a_valid = 0;
        #1;
        checks++; if (bus0.reg_write !== 1'b1 || bus0.wr_rd !== 5'd5 || bus0.wr_data !== 32'h11) begin
            errors++; $display("FAIL first_write: got we=%b rd=%0d data=%h expected 1/5/00000011", bus0.reg_write, bus0.wr_rd, bus0.wr_data); end
        cyc();
        checks++; if (bus0.reg_write !== 1'b0 || bus0.wr_rd !== 5'd5) begin
            errors++; $display("FAIL idle_hold: got we=%b rd=%0d expected 0/5", bus0.reg_write, bus0.wr_rd); end
    endtask

    task automatic test_round_robin();
        logic exp_a;
        reset_dut();
        bus0.a_valid = 1; bus0.a_rd = 3;
        bus0.b_valid = 1; bus0.b_rd = 4;
        for (int i = 0; i < 4; i++) begin
            exp_a = (i % 2 == 0);
            bus0.a_data = 32'hA0 + i; bus0.b_data = 32'hB0 + i;
            #1;
            checks++; if (bus0.a_ready !== exp_a || bus0.b_ready !== !exp_a) begin
                errors++; $display("FAIL rr_grant[%0d]: got a=%b b=%b expected a=%b b=%b", i, bus0.a_ready, bus0.b_ready, exp_a, !exp_a); end
            cyc();
            checks++; if (bus0.reg_write !== 1'b1 || bus0.wr_rd !== (exp_a ? 5'd3 : 5'd4) ||
                          bus0.wr_data !== (exp_a ? 32'hA0 + i : 32'hB0 + i)) begin
                errors++; $display("FAIL rr_write[%0d]: got we=%b rd=%0d data=%h expected rd=%0d", i, bus0.reg_write, bus0.wr_rd, bus0.wr_data, exp_a ? 3 : 4); end
        end
        bus0.a_valid = 0; bus0.b_valid = 0;
        cyc();
        checks++; if (bus0.reg_write !== 1'b0) begin errors++; $display("FAIL rr_drain: got we=%b expected 0", bus0.reg_write); end
    endtask

    task automatic test_fixed_priority();
        reset_dut();
        bus1.a_valid = 1; bus1.a_rd = 3; bus1.a_data = 32'h33;
        bus1.b_valid = 1; bus1.b_rd = 4; bus1.b_data = 32'h44;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (bus1.a_ready !== 1'b1 || bus1.b_ready !== 1'b0) begin
                errors++; $display("FAIL fp_grant[%0d]: got a=%b b=%b expected a=1 b=0", i, bus1.a_ready, bus1.b_ready); end
            cyc();
            checks++; if (bus1.reg_write !== 1'b1 || bus1.wr_rd !== 5'd3) begin
                errors++; $display("FAIL fp_write[%0d]: got we=%b rd=%0d expected 1/3", i, bus1.reg_write, bus1.wr_rd); end
        end
        bus1.a_valid = 0; bus1.b_valid = 0;
        cyc();
    endtask

    task automatic test_scoreboard();
        reset_dut();
        bus0.rs1 = 7; bus0.issue_valid = 1; bus0.issue_rd = 7;
        #1;
        checks++; if (bus0.rs1_busy !== 1'b0) begin errors++; $display("FAIL sb_issue_same_cycle: got %b expected 0", bus0.rs1_busy); end
        cyc();
        bus0.issue_valid = 0;
        #1;
        checks++; if (bus0.rs1_busy !== 1'b1) begin errors++; $display("FAIL sb_busy_after_issue: got %b expected 1", bus0.rs1_busy); end
        bus0.b_valid = 1; bus0.b_rd = 7; bus0.b_data = 32'h77;
        #1;
        checks++; if (bus0.b_ready !== 1'b1) begin errors++; $display("FAIL sb_b_ready: got %b expected 1", bus0.b_ready); end
        cyc();
        bus0.b_valid = 0;
        #1;
        checks++; if (bus0.reg_write !== 1'b1 || bus0.wr_rd !== 5'd7) begin
            errors++; $display("FAIL sb_b_write: got we=%b rd=%0d expected 1/7", bus0.reg_write, bus0.wr_rd); end
`ifdef WB_BYPASS_EN
        checks++; if (bus0.rs1_busy !== 1'b0 || bus0.rs1_fwd !== 32'h77) begin
            errors++; $display("FAIL sb_bypass: got busy=%b fwd=%h expected 0/00000077", bus0.rs1_busy, bus0.rs1_fwd); end
`else
        checks++; if (bus0.rs1_busy !== 1'b1) begin errors++; $display("FAIL sb_busy_write_cycle: got %b expected 1", bus0.rs1_busy); end
`endif
        cyc();
        checks++; if (bus0.rs1_busy !== 1'b0) begin errors++; $display("FAIL sb_busy_cleared: got %b expected 0", bus0.rs1_busy); end
`ifdef WB_BYPASS_EN
        checks++; if (bus0.rs1_fwd !== 32'h0) begin errors++; $display("FAIL sb_fwd_idle: got %h expected 0", bus0.rs1_fwd); end
`endif
    endtask

    task automatic test_collision();
        bus0.rs2 = 9; bus0.issue_valid = 1; bus0.issue_rd = 9;
        cyc();
        bus0.issue_valid = 0;
        bus0.b_valid = 1; bus0.b_rd = 9; bus0.b_data = 32'h99;
        cyc();
        bus0.b_valid = 0;
        #1;
        checks++; if (bus0.reg_write !== 1'b1 || bus0.wr_rd !== 5'd9) begin
            errors++; $display("FAIL col_write: got we=%b rd=%0d expected 1/9", bus0.reg_write, bus0.wr_rd); end
        bus0.issue_valid = 1; bus0.issue_rd = 9;
        cyc();
        bus0.issue_valid = 0;
        #1;
        checks++; if (bus0.rs2_busy !== 1'b1) begin errors++; $display("FAIL col_set_wins: got %b expected 1", bus0.rs2_busy); end
        cyc();
        checks++; if (bus0.rs2_busy !== 1'b1) begin errors++; $display("FAIL col_still_pending: got %b expected 1", bus0.rs2_busy); end
    endtask

    task automatic test_x0();
        bus0.a_valid = 1; bus0.a_rd = 0; bus0.a_data = 32'hFFFF_FFFF;
        #1;
        checks++; if (bus0.a_ready !== 1'b1) begin errors++; $display("FAIL x0_a_ready: got %b expected 1", bus0.a_ready); end
        cyc();
        bus0.a_valid = 0;
        #1;
        checks++; if (bus0.reg_write !== 1'b0) begin errors++; $display("FAIL x0_no_write: got %b expected 0", bus0.reg_write); end
        bus0.a_valid = 1; bus0.a_rd = 1; bus0.a_data = 32'h1;
        bus0.b_valid = 1; bus0.b_rd = 2; bus0.b_data = 32'h2;
        #1;
        checks++; if (bus0.b_ready !== 1'b1 || bus0.a_ready !== 1'b0) begin
            errors++; $display("FAIL x0_grant_update: got a=%b b=%b expected a=0 b=1", bus0.a_ready, bus0.b_ready); end
        cyc();
        bus0.a_valid = 0; bus0.b_valid = 0;
        bus0.issue_valid = 1; bus0.issue_rd = 0; bus0.rs1 = 0;
        #1;
        checks++; if (bus0.wr_rd !== 5'd2 || bus0.wr_data !== 32'h2) begin
            errors++; $display("FAIL x0_b_write: got rd=%0d data=%h expected 2/00000002", bus0.wr_rd, bus0.wr_data); end
        cyc();
        bus0.issue_valid = 0;
        #1;
        checks++; if (bus0.rs1_busy !== 1'b0) begin errors++; $display("FAIL x0_busy: got %b expected 0", bus0.rs1_busy); end
    endtask

    task automatic test_reset_mid();
        bus0.issue_valid = 1; bus0.issue_rd = 3;
        cyc();
        bus0.issue_rd = 7;
        cyc();
        bus0.issue_valid = 0; bus0.rs1 = 3; bus0.rs2 = 7;
        #1;
        checks++; if (bus0.rs1_busy !== 1'b1 || bus0.rs2_busy !== 1'b1) begin
            errors++; $display("FAIL mid_pending: got rs1=%b rs2=%b expected 1/1", bus0.rs1_busy, bus0.rs2_busy); end
        bus0.b_valid = 1; bus0.b_rd = 12; bus0.b_data = 32'hC;
        cyc();
        bus0.b_valid = 0;
        bus0.a_valid = 1; bus0.a_rd = 13; bus0.a_data = 32'hD;
        cyc();
        bus0.a_valid = 0;
        rst_n = 0;
        cyc();
        rst_n = 1;
        #1;
        checks++; if (bus0.reg_write !== 1'b0 || bus0.wr_rd !== 5'd0 || bus0.wr_data !== 32'h0) begin
            errors++; $display("FAIL mid_reset_wr: got we=%b rd=%0d data=%h expected 0/0/0", bus0.reg_write, bus0.wr_rd, bus0.wr_data); end
        checks++; if (bus0.rs1_busy !== 1'b0 || bus0.rs2_busy !== 1'b0) begin
            errors++; $display("FAIL mid_reset_busy: got rs1=%b rs2=%b expected 0/0", bus0.rs1_busy, bus0.rs2_busy); end
        bus0.a_valid = 1; bus0.a_rd = 3; bus0.b_valid = 1; bus0.b_rd = 4;
        #1;
        checks++; if (bus0.a_ready !== 1'b1 || bus0.b_ready !== 1'b0) begin
            errors++; $display("FAIL mid_reset_grant: got a=%b b=%b expected a=1 b=0", bus0.a_ready, bus0.b_ready); end
        cyc();
        bus0.a_valid = 0; bus0.b_valid = 0;
        cyc();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        idle_inputs();
        test_reset();
        test_round_robin();
        test_fixed_priority();
        test_scoreboard();
        test_collision();
        test_x0();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port between two writeback requesters:
  - Port A: main pipeline writeback (ALU/load).
  - Port B: long-latency unit (mul/div).
- Arbitrates between A and B, registers the winning write onto the register-file write port, and keeps a pending-write scoreboard.
- The scoreboard drives rs1/rs2 busy flags so the decode stage can stall on RAW hazards against in-flight long-latency results.

Parameters:
- XLEN, 32, data width of write_data.
- NUM_REGS, 32, architectural register count; index width is clog2(NUM_REGS) = 5.
- ARB_MODE, 0, 0 = round-robin between A and B; 1 = fixed priority, A always wins.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- a_valid  input  1  port A write request.
- a_ready  output  1  port A request accepted this cycle.
- a_rd  input  5  port A destination register.
- a_data  input  XLEN  port A write data.
- b_valid  input  1  port B write request.
- b_ready  output  1  port B request accepted this cycle.
- b_rd  input  5  port B destination register.
- b_data  input  XLEN  port B write data.
- issue_valid  input  1  a long-latency op is issued to B's unit; mark issue_rd pending.
- issue_rd  input  5  destination of the issued op.
- rs1  input  5  decode source 1 to check.
- rs2  input  5  decode source 2 to check.
- rs1_busy  output  1  rs1 has a pending write.
- rs2_busy  output  1  rs2 has a pending write.
- reg_write  output  1  register-file write enable.
- wr_rd  output  5  register-file destination.
- wr_data  output  XLEN  register-file write data.

Behaviour:
- Reset (rst_n low at edge): reg_write=0, wr_rd=0, wr_data=0, pending vector all 0, last_grant=B (so A wins the first contention). Reset overrides any request in the same cycle; requests presented during reset are not accepted and a_ready=b_ready=0.
- Arbitration is combinational:
  - Only one valid: that port gets ready=1.
  - Both valid, ARB_MODE=0: grant the port not equal to last_grant.
  - Both valid, ARB_MODE=1: grant A.
  - Neither valid: no grant.
  - Never both readies in one cycle. Ready may depend on valid.
- A handshake is valid&&ready. last_grant updates only on a handshake.
- Output stage: one cycle of latency. After a handshake at edge N, reg_write=1 with wr_rd/wr_data = the winner's rd/data during cycle N+1. With no handshake, reg_write=0 and wr_rd/wr_data hold their last value.
- The write port never back-pressures; back-to-back grants give one write per cycle.
- rd==0: the handshake still completes and last_grant still updates, but reg_write stays 0 the next cycle and the scoreboard is untouched.
- Scoreboard: pending[NUM_REGS-1:0].
  - Set: issue_valid && issue_rd!=0 sets pending[issue_rd].
  - Clear: reg_write && wr_rd!=0 clears pending[wr_rd] at the edge ending that cycle.
  - Same register set and cleared at the same edge: set wins (the new issue supersedes).
  - pending[0] is always 0.
- rsX_busy = pending[rsX] && rsX!=0, combinational. Port A writes do not consult or require pending; a port A write to a pending register still clears it.
- Requesters hold valid/rd/data stable until ready; the arbiter does not check this.

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined:
  - Adds outputs rs1_fwd, rs2_fwd (XLEN) and a combinational forwarding path.
  - If reg_write && wr_rd==rsX && rsX!=0, then rsX_busy=0 in that cycle and rsX_fwd=wr_data. Otherwise rsX_fwd=0 and rsX_busy follows the normal rule.
  - A same-cycle issue_valid to rsX does not affect this cycle's busy.
- Undefined: no fwd ports; busy stays asserted through the write cycle and drops the cycle after.

Decomposition:
- Shared package:
  - REG_IDX_W=5.
  - XLEN default.
  - ZERO_REG=5'd0.
  - Grant encoding typedef: GNT_A=1'b0, GNT_B=1'b1.
- One natural sub-module: wb_scoreboard (pending vector, set/clear priority, busy lookup, bypass override). The arbiter and output register stay in the top.

Test Plan:
- Reset then idle: hold rst_n=0 for 2 cycles with a_valid=1 -> a_ready=0, reg_write=0, busy=0. After release with a_valid=1, a_rd=5, a_data=0x11 -> next cycle reg_write=1, wr_rd=5, wr_data=0x11.
- Round-robin contention (ARB_MODE=0): A and B valid for 4 cycles (a_rd=3, b_rd=4) -> grants A,B,A,B. reg_write on each following cycle with wr_rd 3,4,3,4. ARB_MODE=1: grants A,A,A,A and b_ready stays 0.
- Scoreboard: issue_valid with issue_rd=7, then rs1=7 -> rs1_busy=1 from the next cycle. B writes rd 7 -> rs1_busy=1 during the reg_write cycle and 0 the cycle after; with WB_BYPASS_EN it is 0 during that cycle and rs1_fwd=b_data.
- Collision: issue_rd=9 in the same cycle that reg_write clears rd 9 -> pending[9] remains 1 and rs2_busy=1 with rs2=9.
- x0 handling: a_rd=0, a_data=0xFFFF_FFFF -> a_ready=1, no reg_write the next cycle. issue_rd=0 -> rs1=0 gives rs1_busy=0.
- Reset mid-operation: pending {3,7} set and B granted, then rst_n=0 for 1 cycle -> reg_write=0, all busy=0, next contention grants A.
